spi_slave_ctrl: RTL and testbench
=================================

Name: spi_slave_ctrl

Overview:
Full-duplex, parametrised SPI slave that runs on the system clock. It oversamples SCK, CS_n and MOSI through a synchroniser, supports all four SPI modes, either bit order and back-to-back multi-word frames, and drives MISO from a one-word transmit buffer. It sits between an external SPI master pin group and an on-chip register or stream interface. The host side uses a valid/ready handshake on TX and a single-cycle strobe on RX, and reports errors.

Parameters:
DATA_W, 8, word width in bits (2..32).
CPOL, 0, SCK idle level.
CPHA, 0, 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading edge / sample on trailing edge.
MSB_FIRST, 1, 1 = MSB shifted first; 0 = LSB first.
SYNC_STAGES, 2, flop depth of the input synchroniser (>=2).

Ports:
clk  in  1  system clock; must run at least 4x SCK frequency.
reset  in  1  asynchronous, active-low.
sck  in  1  SPI clock, asynchronous.
cs_n  in  1  chip select, active-low, asynchronous.
mosi  in  1  serial data in, asynchronous.
miso  out  1  serial data out.
miso_oe  out  1  MISO output enable; high only while the frame is active.
rx_data  out  DATA_W  last complete received word; held until the next word completes.
rx_valid  out  1  one-cycle strobe when rx_data updates.
tx_data  in  DATA_W  word to transmit.
tx_valid  in  1  tx_data valid.
tx_ready  out  1  TX buffer empty; a word is accepted on tx_valid && tx_ready.
frame_active  out  1  high in the XFER state.
word_cnt  out  8  words completed in the current frame; saturates at 255; cleared at frame start.
tx_underrun  out  1  one-cycle pulse when a word is loaded with the TX buffer empty (zeros are sent).
frame_err  out  1  one-cycle pulse when cs_n deasserts with a partial word (1..DATA_W-1 bits).

Behaviour:
- Reset (reset low, asynchronous):
  - Synchroniser flops: sck = CPOL, cs_n = 1, mosi = 0.
  - State = IDLE.
  - miso = 0, miso_oe = 0, rx_data = 0, rx_valid = 0, frame_active = 0, word_cnt = 0, tx_underrun = 0, frame_err = 0.
  - TX buffer empty, so tx_ready = 1.
- Synchronisation and edge detection:
  - All three async inputs pass through SYNC_STAGES flops.
  - Edges are detected between the last two synchronised stages.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge: leading if CPHA = 0, trailing if CPHA = 1. Shift edge is the other one.
- TX buffer:
  - tx_ready = ~buf_full.
  - A handshake fills the buffer on the same clock.
  - A load empties it. If a handshake and a load occur in the same cycle, the load takes the old contents and the new word is stored (buffer stays full).
- State machine:
  - IDLE -> XFER on a synchronised cs_n falling edge. In that cycle:
    - shift register <= buffer contents (or 0 with a tx_underrun pulse if the buffer is empty);
    - bit_cnt <= DATA_W-1, word_cnt <= 0, miso_oe <= 1.
  - XFER, CPHA = 0: miso presents the first bit from the load cycle onward; each shift edge advances to the next bit.
  - XFER, CPHA = 1: the first shift edge presents the first bit.
  - XFER, each sample edge: the synchronised mosi enters the receive shifter at the bit position given by MSB_FIRST.
  - XFER, sample edge with bit_cnt = 0:
    - next cycle: rx_data <= full word, rx_valid = 1 for 1 cycle, word_cnt += 1 (saturating);
    - bit_cnt reloads to DATA_W-1 and the next TX word is loaded with the same underrun rule;
    - the frame continues with no gap required.
  - XFER -> IDLE on a synchronised cs_n rising edge. miso_oe <= 0 and the partial receive word is discarded. If bit_cnt != DATA_W-1, frame_err pulses. rx_valid is never asserted for a partial word.
- Simultaneous events: if a cs_n rising edge and a final sample edge land in the same clock, the word completes (rx_valid pulses) and the frame then ends without frame_err.
- SCK edges seen in IDLE are ignored.
- rx_valid has no backpressure. A consumer that misses the strobe loses the word.
- Latency: from the SCK sample edge at the pin to rx_valid is SYNC_STAGES+1 clk cycles.

Test Plan:
1. Mode 0, DATA_W = 8, MSB first: preload tx 0xA5, master sends 0x3C -> rx_data = 0x3C with one rx_valid pulse; MISO bits 1,0,1,0,0,1,0,1; word_cnt = 1; no errors.
2. Modes 1, 2 and 3 in turn, MSB_FIRST = 0: master sends 0x81, slave sends 0x7E -> rx_data = 0x81; master captures 0x7E on its sample edge in every mode.
3. Back-to-back frame of 3 words (0x11, 0x22, 0x33) with tx words pushed via handshake during the frame -> three rx_valid pulses with the matching rx_data; word_cnt = 3; tx_ready re-asserts after each load.
4. Empty TX buffer at frame start -> tx_underrun pulses once, MISO = 0x00 for that word, reception still correct.
5. cs_n deasserted after 5 bits -> frame_err pulses, no rx_valid, rx_data keeps its previous value, miso_oe = 0, state returns to IDLE.
6. Assert reset mid-word -> all outputs return to their reset values immediately; tx_ready = 1; the next frame after release receives 0x5A correctly.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: oversampled full-duplex SPI slave with one-word TX buffer and RX strobe
// Ports:
//   clk, reset        system clock (>= 4x sck), asynchronous active-low reset
//   sck, cs_n, mosi   asynchronous SPI pins from the master
//   miso, miso_oe     serial data out and its enable (high only during a frame)
//   rx_data, rx_valid last complete received word and its one-cycle strobe
//   tx_data, tx_valid, tx_ready  one-word TX buffer fill handshake
//   frame_active      high while a frame is in progress
//   word_cnt          words completed in the current frame (saturating)
//   tx_underrun       pulse when a word is loaded from an empty buffer
//   frame_err         pulse when cs_n rises mid-word
module spi_slave_ctrl #(
  parameter int DATA_W = 8,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter bit MSB_FIRST = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              frame_active,
  output logic [7:0]        word_cnt,
  output logic              tx_underrun,
  output logic              frame_err
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sck_s, cs_s, mosi_s;
  logic sck_q, cs_q, buf_full;
  logic [DATA_W-1:0] buf_data, tx_sh, rx_sh, rx_nx, load_word;
  logic [CW-1:0] bit_cnt;
  logic sck_new, cs_new, lead, trail, sample_e, shift_e, cs_fall, cs_rise, last_e, load, hs;
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction
  function automatic logic [DATA_W-1:0] shifted(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction
  // edges compare the fully synchronised value against its one-cycle-old copy
  always_comb begin
    sck_new   = sck_s[SYNC_STAGES-1];
    cs_new    = cs_s[SYNC_STAGES-1];
    lead      = (sck_new != sck_q) && (sck_q == CPOL);
    trail     = (sck_new != sck_q) && (sck_new == CPOL);
    sample_e  = CPHA ? trail : lead;
    shift_e   = CPHA ? lead : trail;
    cs_fall   = cs_q & ~cs_new;
    cs_rise   = ~cs_q & cs_new;
    last_e    = (state == XFER) && sample_e && (bit_cnt == '0);
    // no reload when the frame ends on the same clock as the last sample
    load      = (state == IDLE) ? cs_fall : (last_e && !cs_rise);
    hs        = tx_valid && !buf_full;
    load_word = buf_full ? buf_data : '0;
    rx_nx     = MSB_FIRST ? {rx_sh[DATA_W-2:0], mosi_s[SYNC_STAGES-1]}
                          : {mosi_s[SYNC_STAGES-1], rx_sh[DATA_W-1:1]};
  end
  assign tx_ready = ~buf_full;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_s        <= {SYNC_STAGES{CPOL}};
      cs_s         <= '1;
      mosi_s       <= '0;
      sck_q        <= CPOL;
      cs_q         <= 1'b1;
      state        <= IDLE;
      buf_full     <= 1'b0;
      buf_data     <= '0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      bit_cnt      <= LAST;
      miso         <= 1'b0;
      miso_oe      <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_active <= 1'b0;
      word_cnt     <= '0;
      tx_underrun  <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sck_s       <= {sck_s[SYNC_STAGES-2:0], sck};
      cs_s        <= {cs_s[SYNC_STAGES-2:0], cs_n};
      mosi_s      <= {mosi_s[SYNC_STAGES-2:0], mosi};
      sck_q       <= sck_new;
      cs_q        <= cs_new;
      buf_full    <= hs | (buf_full & ~load);
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      if (hs)
        buf_data <= tx_data;
      // CPHA=0 frame start presents the first bit at once; every other load waits for a shift edge
      if (load) begin
        tx_underrun <= ~buf_full;
        if (state == IDLE && !CPHA) begin
          miso  <= first_bit(load_word);
          tx_sh <= shifted(load_word);
        end else
          tx_sh <= load_word;
      end else if (state == XFER && shift_e) begin
        miso  <= first_bit(tx_sh);
        tx_sh <= shifted(tx_sh);
      end
      if (state == IDLE) begin
        if (cs_fall) begin
          state        <= XFER;
          frame_active <= 1'b1;
          miso_oe      <= 1'b1;
          bit_cnt      <= LAST;
          word_cnt     <= '0;
        end
      end else begin
        if (sample_e) begin
          rx_sh   <= rx_nx;
          bit_cnt <= (bit_cnt == '0) ? LAST : bit_cnt - CW'(1);
        end
        if (last_e) begin
          rx_data  <= rx_nx;
          rx_valid <= 1'b1;
          word_cnt <= word_cnt + 8'(word_cnt != 8'hff);
        end
        if (cs_rise) begin
          state        <= IDLE;
          frame_active <= 1'b0;
          miso_oe      <= 1'b0;
          miso         <= 1'b0;
          frame_err    <= !last_e && (bit_cnt != LAST || sample_e);
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: directed scoreboard bench over four instances covering SPI modes 0-3
`timescale 1ns/1ps
module tb_spi_slave_ctrl;
  localparam int HALF = 60;
  logic clk = 1'b0, reset = 1'b0, sck = 1'b0, mosi = 1'b0;
  logic [3:0] cs_n = 4'hf, tx_valid = 4'h0;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] miso, miso_oe, rx_valid, tx_ready, frame_active, tx_underrun, frame_err;
  logic [7:0] rx_data [4];
  logic [7:0] word_cnt [4];
  int total = 0, bad = 0;
  int rxv_cnt [4] = '{default: 0};
  int uf_cnt [4] = '{default: 0};
  int fe_cnt [4] = '{default: 0};
  logic [9:0] qe [$];
  logic [7:0] mi;
  int snap_rxv, snap_uf, snap_fe;
  always #5 clk = ~clk;
  // instance g runs SPI mode g; only mode 0 is MSB first
  for (genvar g = 0; g < 4; g++) begin : u
    spi_slave_ctrl #(
      .DATA_W(8), .CPOL(1'(g / 2)), .CPHA(1'(g % 2)), .MSB_FIRST(g == 0), .SYNC_STAGES(2)
    ) dut (
      .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n[g]), .mosi(mosi),
      .miso(miso[g]), .miso_oe(miso_oe[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
      .tx_data(tx_data), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
      .frame_active(frame_active[g]), .word_cnt(word_cnt[g]),
      .tx_underrun(tx_underrun[g]), .frame_err(frame_err[g])
    );
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i]) begin
        logic [9:0] e;
        rxv_cnt[i]++;
        e = (qe.size() != 0) ? qe.pop_front() : 10'h3ff;
        chk("rx_word", {i[1:0], rx_data[i]}, {22'd0, e});
      end
      if (tx_underrun[i]) uf_cnt[i]++;
      if (frame_err[i]) fe_cnt[i]++;
    end
  end
  task automatic push(input int m, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    tx_data = d;
    tx_valid[m] = 1'b1;
    while (!tx_ready[m] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", 32'(n < 50), 1);
    @(posedge clk);
    #1 tx_valid[m] = 1'b0;
  endtask
  task automatic xfer(input int m, input logic [7:0] mo, input int nb, output logic [7:0] r);
    bit cpol = m[1];
    bit cpha = m[0];
    r = '0;
    if (nb == 8) qe.push_back({m[1:0], mo});
    for (int b = 0; b < nb; b++) begin
      int idx = (m == 0) ? 7 - b : b;
      if (!cpha) begin
        mosi = mo[idx];
        #HALF sck = ~cpol;
        r[idx] = miso[m];
        #HALF sck = cpol;
      end else begin
        sck = ~cpol;
        mosi = mo[idx];
        #HALF sck = cpol;
        r[idx] = miso[m];
        #HALF;
      end
    end
  endtask
  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    #100;
  endtask
  task automatic cs_high(input int m);
    #100 cs_n[m] = 1'b1;
    #200;
    @(negedge clk);
  endtask
  initial begin
    #500us;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    #23;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_miso", miso[i], 0);
      chk("rst_oe", miso_oe[i], 0);
      chk("rst_rx_data", rx_data[i], 0);
      chk("rst_ready", tx_ready[i], 1);
      chk("rst_active", frame_active[i], 0);
      chk("rst_wcnt", word_cnt[i], 0);
    end
    reset = 1'b1;
    @(negedge clk);
    push(0, 8'hA5);
    cs_low(0);
    chk("t1_active", frame_active[0], 1);
    chk("t1_oe", miso_oe[0], 1);
    push(0, 8'h00);
    xfer(0, 8'h3C, 8, mi);
    chk("t1_miso", mi, 8'hA5);
    cs_high(0);
    chk("t1_rxv", rxv_cnt[0], 1);
    chk("t1_wcnt", word_cnt[0], 1);
    chk("t1_uf", uf_cnt[0], 0);
    chk("t1_fe", fe_cnt[0], 0);
    chk("t1_oe_off", miso_oe[0], 0);
    for (int m = 1; m < 4; m++) begin
      sck = m[1];
      #200;
      push(m, 8'h7E);
      cs_low(m);
      push(m, 8'h00);
      xfer(m, 8'h81, 8, mi);
      chk("t2_miso", mi, 8'h7E);
      cs_high(m);
      chk("t2_rxv", rxv_cnt[m], 1);
      chk("t2_rx_data", rx_data[m], 8'h81);
      chk("t2_fe", fe_cnt[m], 0);
      chk("t2_uf", uf_cnt[m], 0);
    end
    sck = 1'b0;
    #200;
    snap_rxv = rxv_cnt[0];
    snap_uf = uf_cnt[0];
    push(0, 8'hC1);
    cs_low(0);
    for (int w = 0; w < 3; w++) begin
      chk("t3_ready", tx_ready[0], 1);
      push(0, 8'(8'hC2 + w));
      xfer(0, 8'(8'h11 * (w + 1)), 8, mi);
      chk("t3_miso", mi, 8'(8'hC1 + w));
      @(negedge clk);
    end
    cs_high(0);
    chk("t3_rxv", rxv_cnt[0] - snap_rxv, 3);
    chk("t3_wcnt", word_cnt[0], 3);
    chk("t3_uf", uf_cnt[0] - snap_uf, 0);
    chk("t3_ready_end", tx_ready[0], 1);
    snap_uf = uf_cnt[0];
    cs_low(0);
    push(0, 8'h00);
    xfer(0, 8'hC3, 8, mi);
    chk("t4_miso", mi, 8'h00);
    cs_high(0);
    chk("t4_uf", uf_cnt[0] - snap_uf, 1);
    chk("t4_rx_data", rx_data[0], 8'hC3);
    snap_rxv = rxv_cnt[0];
    snap_fe = fe_cnt[0];
    push(0, 8'h99);
    cs_low(0);
    xfer(0, 8'hF0, 5, mi);
    cs_high(0);
    chk("t5_fe", fe_cnt[0] - snap_fe, 1);
    chk("t5_rxv", rxv_cnt[0] - snap_rxv, 0);
    chk("t5_rx_data", rx_data[0], 8'hC3);
    chk("t5_oe", miso_oe[0], 0);
    chk("t5_active", frame_active[0], 0);
    push(0, 8'h66);
    cs_low(0);
    xfer(0, 8'h00, 3, mi);
    #7 reset = 1'b0;
    #1;
    chk("t6_miso", miso[0], 0);
    chk("t6_oe", miso_oe[0], 0);
    chk("t6_rx_data", rx_data[0], 0);
    chk("t6_rxv", rx_valid[0], 0);
    chk("t6_active", frame_active[0], 0);
    chk("t6_wcnt", word_cnt[0], 0);
    chk("t6_ready", tx_ready[0], 1);
    chk("t6_fe", frame_err[0], 0);
    cs_n[0] = 1'b1;
    sck = 1'b0;
    #100 reset = 1'b1;
    @(negedge clk);
    push(0, 8'h77);
    cs_low(0);
    push(0, 8'h00);
    xfer(0, 8'h5A, 8, mi);
    chk("t6_miso_after", mi, 8'h77);
    cs_high(0);
    chk("t6_rx_after", rx_data[0], 8'h5A);
    chk("t6_wcnt_after", word_cnt[0], 1);
    #200;
    chk("sb_drain", qe.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
